// File: rtl/cmp_window_stats.sv
// rtl/cmp_window_stats.sv - windowed compare/min/max statistics behind the 3-bit magnitude comparator
// Optional early window close: define CMP_WIN_FLUSH_EN to add flush and cnt_samples ports.
module cmp_window_stats #(
  parameter int WIDTH   = 3,
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] ref_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
`ifdef CMP_WIN_FLUSH_EN
  input  logic             flush,
  output logic [CNT_W-1:0] cnt_samples,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN);

  state_t           state;
  logic [WIDTH-1:0] ref_q;
  logic [CNT_W-1:0] smp_cnt;

  logic             accept;
  logic             close_req;
  logic [WIDTH-1:0] cmp_ref;
  logic             gt_hit, lt_hit, eq_hit;
  logic [CNT_W-1:0] smp_next;
  logic             last_smp;

  // The first sample of a window compares against the live reference, later ones against the latched copy.
  always_comb begin
    accept    = in_valid && in_ready;
    cmp_ref   = (state == IDLE) ? ref_val : ref_q;
    gt_hit    = in_data > cmp_ref;
    lt_hit    = in_data < cmp_ref;
    eq_hit    = in_data == cmp_ref;
    smp_next  = (state == IDLE) ? CNT_W'(1) : smp_cnt + CNT_W'(1);
    last_smp  = smp_next == LAST;
`ifdef CMP_WIN_FLUSH_EN
    close_req = flush;
`else
    close_req = 1'b0;
`endif
  end

`ifdef CMP_WIN_FLUSH_EN
  assign cnt_samples = smp_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ref_q     <= '0;
      min_val   <= '0;
      max_val   <= '0;
      cnt_gt    <= '0;
      cnt_lt    <= '0;
      cnt_eq    <= '0;
      smp_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ref_q   <= ref_val;
            min_val <= in_data;
            max_val <= in_data;
            cnt_gt  <= CNT_W'(gt_hit);
            cnt_lt  <= CNT_W'(lt_hit);
            cnt_eq  <= CNT_W'(eq_hit);
            smp_cnt <= smp_next;
            if (last_smp || close_req) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state     <= ACC;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        ACC: begin
          if (accept) begin
            if (in_data < min_val) min_val <= in_data;
            if (in_data > max_val) max_val <= in_data;
            if (gt_hit) cnt_gt <= cnt_gt + CNT_W'(1);
            if (lt_hit) cnt_lt <= cnt_lt + CNT_W'(1);
            if (eq_hit) cnt_eq <= cnt_eq + CNT_W'(1);
            smp_cnt <= smp_next;
          end
          // A flush closes the window even without a sample; a same-cycle sample is already folded in above.
          if ((accept && last_smp) || close_req) begin
            state     <= HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
// tb/tb_cmp_window_stats.sv - directed table-driven bench for cmp_window_stats (WIN_LEN=4)
module tb_cmp_window_stats;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = '0;
  logic [2:0] ref_val = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] min_val, max_val;
  logic [3:0] cnt_gt, cnt_lt, cnt_eq;
  logic       busy;
`ifdef CMP_WIN_FLUSH_EN
  logic       flush = 1'b0;
  logic [3:0] cnt_samples;
`endif

  int nchecks = 0;
  int nerrors = 0;

  cmp_window_stats #(.WIDTH(3), .WIN_LEN(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .ref_val(ref_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_val(min_val), .max_val(max_val),
    .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq),
`ifdef CMP_WIN_FLUSH_EN
    .flush(flush), .cnt_samples(cnt_samples),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      rv;
    logic [3:0][2:0] s;
    logic [2:0]      mn, mx;
    logic [3:0]      gt, lt, eq;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] rv, a, b, c, d, mn, mx,
                              input logic [3:0] gt, lt, eq);
    vec_t v;
    v.rv = rv; v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.mn = mn; v.mx = mx; v.gt = gt; v.lt = lt; v.eq = eq;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d, input logic [2:0] r);
    in_valid = 1'b1;
    in_data  = d;
    ref_val  = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string nm, input int mn, mx, gt, lt, eq);
    chk({nm, " out_valid"}, out_valid, 1);
    chk({nm, " in_ready"}, in_ready, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " min"}, min_val, mn);
    chk({nm, " max"}, max_val, mx);
    chk({nm, " gt"}, cnt_gt, gt);
    chk({nm, " lt"}, cnt_lt, lt);
    chk({nm, " eq"}, cnt_eq, eq);
  endtask

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not end)");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(3, 1, 3, 5, 7, 1, 7, 2, 1, 1);
    vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    vecs[2] = mk(7, 7, 6, 0, 7, 0, 7, 0, 2, 2);
    vecs[3] = mk(4, 5, 6, 7, 5, 5, 7, 4, 0, 0);
    vecs[4] = mk(2, 4, 1, 2, 0, 0, 4, 1, 2, 1);

    tick(); tick();
    rst = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset min", min_val, 0);
    chk("reset max", max_val, 0);
    chk("reset counters", cnt_gt + cnt_lt + cnt_eq, 0);

    // back-to-back windows, consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      chk($sformatf("vec%0d idle in_ready", v), in_ready, 1);
      for (int i = 0; i < 4; i++) begin
        push(vecs[v].s[i], vecs[v].rv);
        if (i < 3) chk($sformatf("vec%0d busy s%0d", v, i), busy, 1);
      end
      chk_result($sformatf("vec%0d", v), vecs[v].mn, vecs[v].mx,
                 vecs[v].gt, vecs[v].lt, vecs[v].eq);
      tick();
      chk($sformatf("vec%0d consumed out_valid", v), out_valid, 0);
      chk($sformatf("vec%0d consumed in_ready", v), in_ready, 1);
      chk($sformatf("vec%0d held max", v), max_val, vecs[v].mx);
    end

    // backpressure: result stable for 5 cycles, samples offered in HOLD are ignored
    out_ready = 1'b0;
    push(1, 3); push(3, 3); push(5, 3); push(7, 3);
    chk_result("bp c0", 1, 7, 2, 1, 1);
    in_valid = 1'b1;
    in_data  = 3'd0;
    for (int c = 1; c < 5; c++) begin
      tick();
      chk_result($sformatf("bp c%0d", c), 1, 7, 2, 1, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp consumed out_valid", out_valid, 0);
    chk("bp consumed in_ready", in_ready, 1);
    chk("bp consumed busy", busy, 0);

    // reference moves mid-window
    push(3, 3); push(3, 0); push(3, 0); push(3, 5);
    chk_result("refchg", 3, 3, 0, 0, 4);
    tick();

    // gapped input, one sample every 3 cycles
    push(6, 6);
    for (int g = 0; g < 2; g++) begin
      tick();
      chk($sformatf("gap a%0d busy", g), busy, 1);
      chk($sformatf("gap a%0d out_valid", g), out_valid, 0);
    end
    push(0, 6); tick(); tick();
    chk("gap b busy", busy, 1);
    push(6, 6); tick(); tick();
    chk("gap c busy", busy, 1);
    chk("gap c lt", cnt_lt, 1);
    push(2, 6);
    chk_result("gap", 0, 6, 0, 2, 2);
    tick();

    // reset mid-window discards everything
    push(1, 7); push(2, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst lt", cnt_lt, 0);
    chk("rst min", min_val, 0);
    push(7, 7); push(7, 7); push(7, 7); push(7, 7);
    chk_result("post rst", 7, 7, 0, 0, 4);
    tick();

`ifdef CMP_WIN_FLUSH_EN
    push(2, 4);
    flush = 1'b1;
    push(5, 4);
    flush = 1'b0;
    chk_result("flush", 2, 5, 1, 1, 0);
    chk("flush cnt_samples", cnt_samples, 2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle flush out_valid", out_valid, 0);
    chk("idle flush busy", busy, 0);
    flush = 1'b1;
    push(6, 1);
    flush = 1'b0;
    chk_result("one-sample flush", 6, 6, 1, 0, 0);
    chk("one-sample cnt_samples", cnt_samples, 1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
